// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// The main entry drives the id_* outputs; the skid entry absorbs one instruction
// when decode stalls, so if_ready_o can be a plain register.
// flush_i squashes both entries and presents a NOP bubble.
// Optional feature: define IF_ID_PERF_EN to add bubble/flush performance counters.
module if_id_pipe_reg #(
    parameter int unsigned            XLEN      = 64,
    parameter int unsigned            ILEN      = 32,
    parameter logic [XLEN-1:0]        RESET_PC  = 64'h8000_0000,
    parameter logic [ILEN-1:0]        NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [ILEN-1:0] if_instr_i,
    input  logic            if_time_set_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [ILEN-1:0] id_instr_o,
    output logic            id_time_set_o,
`ifdef IF_ID_PERF_EN
    output logic [31:0]     perf_bubble_cnt_o,
    output logic [31:0]     perf_flush_cnt_o,
`endif
    input  logic            flush_i
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic            if_ready_r;
    logic            id_valid_r;
    logic [XLEN-1:0] main_pc_r;
    logic [ILEN-1:0] main_instr_r;
    logic            main_ts_r;
    logic [XLEN-1:0] skid_pc_r;
    logic [ILEN-1:0] skid_instr_r;
    logic            skid_ts_r;

    logic            accept_in_s;
    logic            take_out_s;
    logic            load_main_in_s;
    logic            load_main_skid_s;
    logic            load_skid_s;
    logic            clear_main_s;

    assign accept_in_s = if_valid_i & if_ready_r;
    assign take_out_s  = id_valid_r & id_ready_i;

    assign if_ready_o    = if_ready_r;
    assign id_valid_o    = id_valid_r;
    assign id_pc_o       = main_pc_r;
    assign id_instr_o    = main_instr_r;
    assign id_time_set_o = main_ts_r;

    // Next-state and datapath-steering decode; flush overrides every handshake.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        clear_main_s     = 1'b0;
        if (flush_i) begin
            state_nxt_s  = ST_EMPTY;
            clear_main_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_in_s) begin
                        state_nxt_s    = ST_FULL;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s    = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (accept_in_s && take_out_s) begin
                        state_nxt_s    = ST_FULL;
                        load_main_in_s = 1'b1;
                    end else if (accept_in_s) begin
                        state_nxt_s    = ST_SKID;
                        load_skid_s    = 1'b1;
                    end else if (take_out_s) begin
                        state_nxt_s    = ST_EMPTY;
                        clear_main_s   = 1'b1;
                    end else begin
                        state_nxt_s    = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // Skid always drains into main first, keeping order intact.
                    if (take_out_s) begin
                        state_nxt_s      = ST_FULL;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s      = ST_SKID;
                    end
                end
                default: begin
                    state_nxt_s  = ST_EMPTY;
                    clear_main_s = 1'b1;
                end
            endcase
        end
    end

    // State register plus registered handshake outputs derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            id_valid_r <= 1'b0;
            if_ready_r <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            id_valid_r <= (state_nxt_s != ST_EMPTY);
            if_ready_r <= (state_nxt_s != ST_SKID);
        end
    end

    // Main and skid payload registers; an emptied main shows a NOP with PC held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_pc_r    <= RESET_PC;
            main_instr_r <= NOP_INSTR;
            main_ts_r    <= 1'b0;
            skid_pc_r    <= '0;
            skid_instr_r <= NOP_INSTR;
            skid_ts_r    <= 1'b0;
        end else begin
            if (load_main_in_s) begin
                main_pc_r    <= if_pc_i;
                main_instr_r <= if_instr_i;
                main_ts_r    <= if_time_set_i;
            end else if (load_main_skid_s) begin
                main_pc_r    <= skid_pc_r;
                main_instr_r <= skid_instr_r;
                main_ts_r    <= skid_ts_r;
            end else if (clear_main_s) begin
                main_instr_r <= NOP_INSTR;
                main_ts_r    <= 1'b0;
            end else begin
                main_pc_r    <= main_pc_r;
            end
            if (load_skid_s) begin
                skid_pc_r    <= if_pc_i;
                skid_instr_r <= if_instr_i;
                skid_ts_r    <= if_time_set_i;
            end else if (flush_i) begin
                skid_instr_r <= NOP_INSTR;
                skid_ts_r    <= 1'b0;
            end else begin
                skid_pc_r    <= skid_pc_r;
            end
        end
    end

`ifdef IF_ID_PERF_EN
    logic [31:0] perf_bubble_cnt_r;
    logic [31:0] perf_flush_cnt_r;

    assign perf_bubble_cnt_o = perf_bubble_cnt_r;
    assign perf_flush_cnt_o  = perf_flush_cnt_r;

    // Saturating counters: idle decode cycles and flushes that squash real work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubble_cnt_r <= 32'd0;
            perf_flush_cnt_r  <= 32'd0;
        end else begin
            if (!id_valid_r && (perf_bubble_cnt_r != 32'hFFFF_FFFF)) begin
                perf_bubble_cnt_r <= perf_bubble_cnt_r + 32'd1;
            end
            if (flush_i && id_valid_r && (perf_flush_cnt_r != 32'hFFFF_FFFF)) begin
                perf_flush_cnt_r <= perf_flush_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule
